// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Used by the MEM stage request FSM and the MEM/WB register.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          MEM_TIMEOUT = 255;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs, data-memory req/ack bus and MEM/WB outputs of the memory stage.
// The stage takes the slave side; the surrounding pipeline and memory take the master side.
interface mem_wb_stage_if;
  logic [31:0] ALUIn;
  logic [31:0] DbIn;
  logic [4:0]  AwIn;
  logic        RegWrIn;
  logic        MemWrIn;
  logic        MemToRegIn;
  logic [31:0] instrIn;

  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memAck;

  logic        stall;
  logic [31:0] WbDataOut;
  logic [4:0]  AwOut;
  logic        RegWrOut;
  logic [31:0] instrOut;
  logic        memErr;

  modport master (
    output ALUIn, DbIn, AwIn, RegWrIn, MemWrIn, MemToRegIn, instrIn,
    output memRData, memAck,
    input  memReq, memWe, memAddr, memWData,
    input  stall, WbDataOut, AwOut, RegWrOut, instrOut, memErr
  );

  modport slave (
    input  ALUIn, DbIn, AwIn, RegWrIn, MemWrIn, MemToRegIn, instrIn,
    input  memRData, memAck,
    output memReq, memWe, memAddr, memWData,
    output stall, WbDataOut, AwOut, RegWrOut, instrOut, memErr
  );
endinterface

// File: rtl/mem_req_fsm.sv
// Data-memory req/ack sequencer: IDLE -> WAIT (until ack or timeout) -> DONE.
// Holds the registered request, the captured load data and the sticky timeout flag.
module mem_req_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memOp,
  input  logic        memWrIn,
  input  logic [31:0] aluIn,
  input  logic [31:0] dbIn,
  input  logic [31:0] memRData,
  input  logic        memAck,
  output mem_state_t  state,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [31:0] rdBuf,
  output logic        memErr
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_t state_nxt;
  logic [7:0] cnt;
  logic       expired;

  assign expired = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (memOp) state_nxt = WAIT;
      WAIT:    if (memAck || expired) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= 32'h0;
      memWData <= 32'h0;
      rdBuf    <= 32'h0;
      memErr   <= 1'b0;
      cnt      <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (memOp) begin
            memReq   <= 1'b1;
            memWe    <= memWrIn;
            memAddr  <= aluIn;
            memWData <= dbIn;
            cnt      <= 8'h0;
          end
        end
        WAIT: begin
          // Ack wins over an expiring counter on the same cycle.
          if (memAck) begin
            rdBuf  <= memRData;
            memReq <= 1'b0;
          end else if (expired) begin
            memErr <= 1'b1;
            rdBuf  <= 32'h0;
            memReq <= 1'b0;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS MEM stage plus MEM/WB register; stalls upstream while a data-memory access is open.
// Bubbles are written back during the stall, the real instruction on the DONE edge.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int          TIMEOUT = MEM_TIMEOUT,
  parameter logic [31:0] NOP     = NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  mem_wb_stage_if.slave bus
);

  mem_state_t  state;
  logic        memOp;
  logic        wb_real;
  logic [31:0] rdBuf;
  logic        memReq, memWe, memErr;
  logic [31:0] memAddr, memWData;
  logic [31:0] wb_data;
  logic [4:0]  aw;
  logic        regwr;
  logic [31:0] instr;

  assign memOp = bus.MemWrIn | bus.MemToRegIn;

  mem_req_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .memOp    (memOp),
    .memWrIn  (bus.MemWrIn),
    .aluIn    (bus.ALUIn),
    .dbIn     (bus.DbIn),
    .memRData (bus.memRData),
    .memAck   (bus.memAck),
    .state    (state),
    .memReq   (memReq),
    .memWe    (memWe),
    .memAddr  (memAddr),
    .memWData (memWData),
    .rdBuf    (rdBuf),
    .memErr   (memErr)
  );

  // DONE releases the stall so upstream advances on the same edge the WB register loads.
  assign bus.stall = (state == WAIT) || ((state == IDLE) && memOp);
  assign wb_real   = (state == DONE) || ((state == IDLE) && !memOp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data <= 32'h0;
      aw      <= 5'd0;
      regwr   <= 1'b0;
      instr   <= NOP;
    end else if (wb_real) begin
      wb_data <= ((state == DONE) && bus.MemToRegIn) ? rdBuf : bus.ALUIn;
      aw      <= bus.AwIn;
      regwr   <= bus.RegWrIn;
      instr   <= bus.instrIn;
    end else begin
      wb_data <= 32'h0;
      aw      <= 5'd0;
      regwr   <= 1'b0;
      instr   <= NOP;
    end
  end

  assign bus.memReq    = memReq;
  assign bus.memWe     = memWe;
  assign bus.memAddr   = memAddr;
  assign bus.memWData  = memWData;
  assign bus.memErr    = memErr;
  assign bus.WbDataOut = wb_data;
  assign bus.AwOut     = aw;
  assign bus.RegWrOut  = regwr;
  assign bus.instrOut  = instr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (TIMEOUT=4): ALU pass-through, load, store, timeout,
// reset in WAIT and back-to-back loads, with hand-computed expected values.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Per-cycle activity counters, sampled mid-cycle.
  int   mon_stall = 0;
  int   mon_req   = 0;
  int   mon_rise  = 0;
  logic req_q     = 1'b0;
  always @(negedge clk) begin
    if (bus.stall) mon_stall <= mon_stall + 1;
    if (bus.memReq) mon_req <= mon_req + 1;
    if (bus.memReq && !req_q) mon_rise <= mon_rise + 1;
    req_q <= bus.memReq;
  end

  int s_stall, s_req, s_rise;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] db, input logic [4:0] aw,
                       input logic rw, input logic mw, input logic m2r, input logic [31:0] ins);
    bus.ALUIn      = alu;
    bus.DbIn       = db;
    bus.AwIn       = aw;
    bus.RegWrIn    = rw;
    bus.MemWrIn    = mw;
    bus.MemToRegIn = m2r;
    bus.instrIn    = ins;
  endtask

  task automatic snap();
    s_stall = mon_stall;
    s_req   = mon_req;
    s_rise  = mon_rise;
  endtask

  initial begin
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    bus.memAck   = 1'b0;
    bus.memRData = 32'h0;
    step();
    step();

    // Reset state
    expect_eq("rst memReq",   32'(bus.memReq), 32'd0);
    expect_eq("rst memWe",    32'(bus.memWe), 32'd0);
    expect_eq("rst memAddr",  bus.memAddr, 32'h0);
    expect_eq("rst memWData", bus.memWData, 32'h0);
    expect_eq("rst WbData",   bus.WbDataOut, 32'h0);
    expect_eq("rst AwOut",    32'(bus.AwOut), 32'd0);
    expect_eq("rst RegWr",    32'(bus.RegWrOut), 32'd0);
    expect_eq("rst instrOut", bus.instrOut, 32'h0);
    expect_eq("rst memErr",   32'(bus.memErr), 32'd0);
    reset = 1'b1;

    // ALU op: one-cycle latency, no stall
    step();
    snap();
    drive(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0085_2020);
    #1 expect_eq("alu stall", 32'(bus.stall), 32'd0);
    step();
    expect_eq("alu WbData", bus.WbDataOut, 32'h1234);
    expect_eq("alu AwOut",  32'(bus.AwOut), 32'd5);
    expect_eq("alu RegWr",  32'(bus.RegWrOut), 32'd1);
    expect_eq("alu instr",  bus.instrOut, 32'h0085_2020);
    drive(32'hDEAD_0001, 32'h0, 5'd17, 1'b0, 1'b0, 1'b0, 32'h0000_0001);
    step();
    expect_eq("alu2 WbData", bus.WbDataOut, 32'hDEAD_0001);
    expect_eq("alu2 AwOut",  32'(bus.AwOut), 32'd17);
    expect_eq("alu2 RegWr",  32'(bus.RegWrOut), 32'd0);
    expect_eq("alu stall cycles", 32'(mon_stall - s_stall), 32'd0);

    // Load with ack at T+1
    snap();
    drive(32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h8C47_0040);
    #1 expect_eq("ld stall T", 32'(bus.stall), 32'd1);
    step();
    expect_eq("ld memReq T1",  32'(bus.memReq), 32'd1);
    expect_eq("ld memAddr",    bus.memAddr, 32'h40);
    expect_eq("ld memWe",      32'(bus.memWe), 32'd0);
    expect_eq("ld stall T1",   32'(bus.stall), 32'd1);
    expect_eq("ld bubble ins", bus.instrOut, 32'h0);
    expect_eq("ld bubble rw",  32'(bus.RegWrOut), 32'd0);
    bus.memAck   = 1'b1;
    bus.memRData = 32'hCAFE_F00D;
    step();
    bus.memAck = 1'b0;
    expect_eq("ld memReq T2", 32'(bus.memReq), 32'd0);
    expect_eq("ld stall T2",  32'(bus.stall), 32'd0);
    step();
    expect_eq("ld WbData", bus.WbDataOut, 32'hCAFE_F00D);
    expect_eq("ld RegWr",  32'(bus.RegWrOut), 32'd1);
    expect_eq("ld AwOut",  32'(bus.AwOut), 32'd7);
    expect_eq("ld instr",  bus.instrOut, 32'h8C47_0040);
    expect_eq("ld stall cycles", 32'(mon_stall - s_stall), 32'd2);
    expect_eq("ld req cycles",   32'(mon_req - s_req), 32'd1);

    // Store with ack at T+4
    snap();
    drive(32'h80, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 32'hAC45_0080);
    #1 expect_eq("st stall T", 32'(bus.stall), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      expect_eq("st memReq", 32'(bus.memReq), 32'd1);
      expect_eq("st stall",  32'(bus.stall), 32'd1);
      expect_eq("st bubble", bus.instrOut, 32'h0);
      if (k == 1) begin
        expect_eq("st memWe",    32'(bus.memWe), 32'd1);
        expect_eq("st memWData", bus.memWData, 32'hA5A5_A5A5);
      end
      if (k == 4) bus.memAck = 1'b1;
    end
    step();
    bus.memAck = 1'b0;
    expect_eq("st memReq done", 32'(bus.memReq), 32'd0);
    expect_eq("st stall done",  32'(bus.stall), 32'd0);
    step();
    expect_eq("st stall cycles", 32'(mon_stall - s_stall), 32'd5);
    expect_eq("st req cycles",   32'(mon_req - s_req), 32'd4);
    expect_eq("st WbData", bus.WbDataOut, 32'h80);
    expect_eq("st RegWr",  32'(bus.RegWrOut), 32'd0);
    expect_eq("st instr",  bus.instrOut, 32'hAC45_0080);

    // Load that times out (TIMEOUT=4)
    snap();
    drive(32'h44, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 32'h8C49_0044);
    begin
      int waited = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        waited++;
        if (!bus.stall) break;
      end
      expect_eq("to cycles to DONE", 32'(waited), 32'd5);
    end
    expect_eq("to memErr set", 32'(bus.memErr), 32'd1);
    expect_eq("to memReq off", 32'(bus.memReq), 32'd0);
    step();
    expect_eq("to req cycles", 32'(mon_req - s_req), 32'd4);
    expect_eq("to stall cycles", 32'(mon_stall - s_stall), 32'd5);
    expect_eq("to WbData", bus.WbDataOut, 32'h0);
    expect_eq("to RegWr",  32'(bus.RegWrOut), 32'd1);
    expect_eq("to AwOut",  32'(bus.AwOut), 32'd9);
    drive(32'h55, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    bus.memAck = 1'b1;
    step();
    bus.memAck = 1'b0;
    expect_eq("stray memReq", 32'(bus.memReq), 32'd0);
    expect_eq("stray memErr", 32'(bus.memErr), 32'd1);
    step();
    expect_eq("stray memReq2", 32'(bus.memReq), 32'd0);
    expect_eq("stray WbData",  bus.WbDataOut, 32'h55);

    // Reset asserted in WAIT
    drive(32'h60, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 32'h8C43_0060);
    step();
    step();
    expect_eq("rw memReq pre", 32'(bus.memReq), 32'd1);
    reset = 1'b0;
    #1;
    expect_eq("rw memReq",   32'(bus.memReq), 32'd0);
    expect_eq("rw memAddr",  bus.memAddr, 32'h0);
    expect_eq("rw memErr",   32'(bus.memErr), 32'd0);
    expect_eq("rw WbData",   bus.WbDataOut, 32'h0);
    expect_eq("rw AwOut",    32'(bus.AwOut), 32'd0);
    expect_eq("rw RegWr",    32'(bus.RegWrOut), 32'd0);
    expect_eq("rw instrOut", bus.instrOut, 32'h0);
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    reset = 1'b1;
    drive(32'h777, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0123_4567);
    bus.memAck   = 1'b1;
    bus.memRData = 32'hBAD0_BAD0;
    #1 expect_eq("rw post stall", 32'(bus.stall), 32'd0);
    step();
    bus.memAck = 1'b0;
    expect_eq("late ack memReq", 32'(bus.memReq), 32'd0);
    expect_eq("post WbData", bus.WbDataOut, 32'h777);
    expect_eq("post AwOut",  32'(bus.AwOut), 32'd12);
    expect_eq("post RegWr",  32'(bus.RegWrOut), 32'd1);

    // Back-to-back loads, each acked in its first WAIT cycle
    snap();
    drive(32'h100, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 32'h8C0A_0100);
    step();
    expect_eq("b2b A memAddr", bus.memAddr, 32'h100);
    bus.memAck   = 1'b1;
    bus.memRData = 32'h1111_1111;
    step();
    bus.memAck = 1'b0;
    expect_eq("b2b A stall done", 32'(bus.stall), 32'd0);
    step();
    drive(32'h104, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 32'h8C0B_0104);
    expect_eq("b2b A WbData", bus.WbDataOut, 32'h1111_1111);
    expect_eq("b2b A AwOut",  32'(bus.AwOut), 32'd10);
    expect_eq("b2b B memReq idle", 32'(bus.memReq), 32'd0);
    step();
    expect_eq("b2b B memAddr", bus.memAddr, 32'h104);
    expect_eq("b2b B memReq",  32'(bus.memReq), 32'd1);
    bus.memAck   = 1'b1;
    bus.memRData = 32'h2222_2222;
    step();
    bus.memAck = 1'b0;
    step();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_eq("b2b B WbData", bus.WbDataOut, 32'h2222_2222);
    expect_eq("b2b B AwOut",  32'(bus.AwOut), 32'd11);
    expect_eq("b2b B instr",  bus.instrOut, 32'h8C0B_0104);
    expect_eq("b2b stall cycles", 32'(mon_stall - s_stall), 32'd4);
    expect_eq("b2b req cycles",   32'(mon_req - s_req), 32'd2);
    expect_eq("b2b req rises",    32'(mon_rise - s_rise), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
